line_buffer_reader: RTL and testbench
=====================================

LINE_BUFFER_READER -- requirements
Module: line_buffer_reader

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state on rising edge.
REQ-002 SHALL have port n_rst, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port bla_done, input, 1, start strobe from the Bresenham wrapper marking line_buffer valid.
REQ-004 SHALL have port line_buffer, input, 4096, 64x64 bitmap; bit index = y*64 + x.
REQ-005 SHALL have port out_ready, input, 1, downstream pixel-writer accepts the current pixel.
REQ-006 SHALL have port out_valid, output, 1, out_x/out_y hold a set pixel.
REQ-007 SHALL have port out_x, output, 6, pixel column.
REQ-008 SHALL have port out_y, output, 6, pixel row.
REQ-009 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-010 SHALL have port scan_done, output, 1, one-cycle pulse at scan completion.
REQ-011 SHALL have port pix_count, output, 13, count of pixels accepted in the current or last scan (0..4096).

Function
REQ-012 SHALL implement the states IDLE, SCAN, EMIT and DONE, with a 12-bit index cnt and a 4096-bit snapshot register snap.
REQ-013 SHALL, in IDLE with bla_done=1 at a clock edge, copy line_buffer into snap, clear cnt and pix_count, and move to SCAN, with busy=1 from the next cycle.
REQ-014 SHALL ignore bla_done in SCAN, EMIT and DONE, with no restart and no change to snap.
REQ-015 SHALL scan only snap, so line_buffer changes after capture have no effect.
REQ-016 SHALL, in SCAN with snap[cnt]=0, increment cnt, or go to DONE if cnt=4095.
REQ-017 SHALL, in SCAN with snap[cnt]=1, register out_x=cnt[5:0] and out_y=cnt[11:6] and go to EMIT.
REQ-018 SHALL drive out_valid=1 exactly while in EMIT (Moore output), independent of out_ready.
REQ-019 SHALL hold out_x and out_y stable while out_valid=1 and out_ready=0, with no limit on stall length.
REQ-020 SHALL, in EMIT with out_ready=1 at an edge, increment pix_count and then increment cnt and return to SCAN, or go to DONE if cnt=4095.
REQ-021 SHALL emit each set bit exactly once, in ascending index order (row-major: x fastest).
REQ-022 SHALL, in DONE, drive scan_done=1 for one cycle and then go to IDLE.
REQ-023 SHALL hold pix_count after DONE until the next start.
REQ-024 SHALL run, for an empty snapshot, 4096 SCAN cycles followed by DONE, with out_valid never asserted and pix_count=0.
REQ-025 SHALL, with out_ready held at 1, take 1 cycle per clear bit and 2 cycles per set bit; a full bitmap therefore takes 8192 cycles plus DONE.
REQ-026 SHALL NOT wrap cnt past 4095; the terminal index always exits to DONE.
REQ-027 SHALL leave out_x and out_y at their last values when out_valid=0; these values carry no meaning outside EMIT.

Reset
REQ-028 SHALL, on n_rst=0 at any time including mid-scan, immediately force state=IDLE, cnt=0, snap=0, out_valid=0, out_x=0, out_y=0, busy=0, scan_done=0 and pix_count=0.
REQ-029 SHALL, after reset release, remain in IDLE until bla_done=1; a bla_done asserted during reset is lost.

Verification
REQ-030 SHALL verify reset: assert n_rst=0 with random inputs -> all outputs 0; after release with bla_done=0 -> busy stays 0.
REQ-031 SHALL verify corners: set bits 0 and 4095, out_ready=1 -> emits (0,0) then (63,63), pix_count=2, scan_done pulses once, and busy falls the cycle after.
REQ-032 SHALL verify a diagonal: set bits y*64+y for y=0..23 (line (0,0)-(23,23)) -> 24 pixels (k,k) in order k=0..23, pix_count=24.
REQ-033 SHALL verify backpressure: on the first pixel (5,2), hold out_ready=0 for 5 cycles -> out_valid=1, out_x=5 and out_y=2 stable; on release, accepted once with no duplicate.
REQ-034 SHALL verify ignored restart: pulse bla_done mid-scan and change line_buffer -> output sequence and pix_count match the original snapshot.
REQ-035 SHALL verify mid-scan reset and empty bitmap: assert n_rst=0 in EMIT -> outputs 0 at once; a subsequent empty-bitmap scan -> scan_done after 4096 SCAN cycles, no out_valid, pix_count=0.

Source files
------------

// File: rtl/line_buffer_reader.sv
// Walks a captured 64x64 bitmap in row-major order and hands each set pixel
// to a downstream writer over a valid/ready handshake.
module line_buffer_reader (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          bla_done,
  input  logic [4095:0] line_buffer,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [5:0]    out_x,
  output logic [5:0]    out_y,
  output logic          busy,
  output logic          scan_done,
  output logic [12:0]   pix_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [11:0]   cnt_r;
  logic [11:0]   cnt_nxt_s;
  logic [4095:0] snap_r;
  logic [5:0]    out_x_r;
  logic [5:0]    out_y_r;
  logic [12:0]   pix_count_r;
  logic          out_valid_r;
  logic          busy_r;
  logic          scan_done_r;
  logic          cur_bit_s;
  logic          last_s;
  logic          capture_s;
  logic          load_pix_s;
  logic          accept_s;

  assign cur_bit_s = snap_r[cnt_r];
  assign last_s    = (cnt_r == 12'd4095);

  // Next-state and index logic; the terminal index always exits to DONE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    load_pix_s  = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bla_done) begin
          capture_s   = 1'b1;
          cnt_nxt_s   = 12'd0;
          state_nxt_s = ST_SCAN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (cur_bit_s) begin
          load_pix_s  = 1'b1;
          state_nxt_s = ST_EMIT;
        end else if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s   = cnt_r + 12'd1;
          state_nxt_s = ST_SCAN;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          accept_s = 1'b1;
          if (last_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            cnt_nxt_s   = cnt_r + 12'd1;
            state_nxt_s = ST_SCAN;
          end
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 12'd0;
      end
    endcase
  end

  // State register and scan index.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 12'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Snapshot of the bitmap; only loaded on an accepted start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      snap_r <= {4096{1'b0}};
    end else if (capture_s) begin
      snap_r <= line_buffer;
    end else begin
      snap_r <= snap_r;
    end
  end

  // Pixel coordinates latch on the SCAN->EMIT hop and hold through any stall.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_x_r <= 6'd0;
      out_y_r <= 6'd0;
    end else if (load_pix_s) begin
      out_x_r <= cnt_r[5:0];
      out_y_r <= cnt_r[11:6];
    end else begin
      out_x_r <= out_x_r;
      out_y_r <= out_y_r;
    end
  end

  // Accepted-pixel count, held after DONE until the next start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pix_count_r <= 13'd0;
    end else if (capture_s) begin
      pix_count_r <= 13'd0;
    end else if (accept_s) begin
      pix_count_r <= pix_count_r + 13'd1;
    end else begin
      pix_count_r <= pix_count_r;
    end
  end

  // Status flags decoded from the next state so they line up with state_r.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      scan_done_r <= 1'b0;
    end else begin
      out_valid_r <= (state_nxt_s == ST_EMIT);
      busy_r      <= (state_nxt_s != ST_IDLE);
      scan_done_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign out_valid = out_valid_r;
  assign out_x     = out_x_r;
  assign out_y     = out_y_r;
  assign busy      = busy_r;
  assign scan_done = scan_done_r;
  assign pix_count = pix_count_r;

  line_buffer_reader_chk u_chk (
    .clk       (clk),
    .n_rst     (n_rst),
    .out_valid (out_valid_r),
    .out_ready (out_ready),
    .out_x     (out_x_r),
    .out_y     (out_y_r),
    .busy      (busy_r),
    .scan_done (scan_done_r),
    .pix_count (pix_count_r)
  );

endmodule

// Protocol properties of the pixel handshake and status outputs.
module line_buffer_reader_chk (
  input logic        clk,
  input logic        n_rst,
  input logic        out_valid,
  input logic        out_ready,
  input logic [5:0]  out_x,
  input logic [5:0]  out_y,
  input logic        busy,
  input logic        scan_done,
  input logic [12:0] pix_count
);

  a_stall_stable: assert property (@(posedge clk) disable iff (!n_rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_x) && $stable(out_y)));

  a_done_single: assert property (@(posedge clk) disable iff (!n_rst)
    scan_done |=> !scan_done);

  a_active_busy: assert property (@(posedge clk) disable iff (!n_rst)
    (out_valid || scan_done) |-> busy);

  a_valid_done_excl: assert property (@(posedge clk) disable iff (!n_rst)
    !(out_valid && scan_done));

  a_count_range: assert property (@(posedge clk) disable iff (!n_rst)
    pix_count <= 13'd4096);

endmodule

// File: tb/tb_line_buffer_reader.sv
// Directed bench for line_buffer_reader: reset, corners, diagonal,
// backpressure, ignored restart, mid-scan reset and empty scan.
module tb_line_buffer_reader;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          bla_done;
  logic [4095:0] line_buffer;
  logic          out_ready;
  logic          out_valid;
  logic [5:0]    out_x;
  logic [5:0]    out_y;
  logic          busy;
  logic          scan_done;
  logic [12:0]   pix_count;

  int checks = 0;
  int failures = 0;

  int   got_x[$];
  int   got_y[$];
  int   done_cycle;
  int   valid_seen;
  logic busy_after;
  logic sd_after;
  logic timed_out;

  line_buffer_reader dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .bla_done    (bla_done),
    .line_buffer (line_buffer),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_x       (out_x),
    .out_y       (out_y),
    .busy        (busy),
    .scan_done   (scan_done),
    .pix_count   (pix_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse bla_done for one edge with the given bitmap presented.
  task automatic start_scan(input logic [4095:0] bm);
    line_buffer = bm;
    bla_done = 1'b1;
    tick();
    bla_done = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL start_busy got=%0b exp=1", busy);
    end
  endtask

  // Record accepted pixels until scan_done; cycle 0 is the first SCAN cycle.
  task automatic collect(input int budget);
    int ncyc;
    got_x.delete();
    got_y.delete();
    ncyc = 0;
    done_cycle = -1;
    valid_seen = 0;
    timed_out = 1'b0;
    busy_after = 1'b1;
    sd_after = 1'b1;
    while (1) begin
      if (out_valid) valid_seen++;
      if (out_valid && out_ready) begin
        got_x.push_back(int'(out_x));
        got_y.push_back(int'(out_y));
      end
      if (scan_done) begin
        done_cycle = ncyc;
        tick();
        busy_after = busy;
        sd_after = scan_done;
        break;
      end
      if (ncyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
      tick();
      ncyc++;
    end
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL scan_timeout got=no_scan_done exp=scan_done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bla_done = 1'($urandom_range(1, 0));
      out_ready = 1'($urandom_range(1, 0));
      for (int w = 0; w < 128; w++) line_buffer[w*32 +: 32] = $urandom;
      tick();
    end
    checks++;
    if ({out_valid, out_x, out_y, busy, scan_done, pix_count} !== 28'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%0b/%0d/%0d/%0b/%0b/%0d exp=all zero",
               out_valid, out_x, out_y, busy, scan_done, pix_count);
    end
    bla_done = 1'b0;
    out_ready = 1'b1;
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle_busy cycle=%0d got=%0b exp=0", i, busy);
      end
    end
  endtask

  task automatic test_corners();
    logic [4095:0] bm;
    bm = {4096{1'b0}};
    bm[0] = 1'b1;
    bm[4095] = 1'b1;
    out_ready = 1'b1;
    start_scan(bm);
    collect(6000);
    checks++;
    if (got_x.size() !== 2) begin
      failures++;
      $display("FAIL corners_count got=%0d exp=2", got_x.size());
    end else begin
      checks++;
      if (got_x[0] !== 0 || got_y[0] !== 0 || got_x[1] !== 63 || got_y[1] !== 63) begin
        failures++;
        $display("FAIL corners_pixels got=(%0d,%0d),(%0d,%0d) exp=(0,0),(63,63)",
                 got_x[0], got_y[0], got_x[1], got_y[1]);
      end
    end
    checks++;
    if (pix_count !== 13'd2) begin
      failures++;
      $display("FAIL corners_pix_count got=%0d exp=2", pix_count);
    end
    checks++;
    if (done_cycle !== 4098) begin
      failures++;
      $display("FAIL corners_latency got=%0d exp=4098", done_cycle);
    end
    checks++;
    if (busy_after !== 1'b0 || sd_after !== 1'b0) begin
      failures++;
      $display("FAIL corners_after_done got=busy%0b/done%0b exp=busy0/done0", busy_after, sd_after);
    end
  endtask

  task automatic test_diagonal();
    logic [4095:0] bm;
    bm = {4096{1'b0}};
    for (int y = 0; y < 24; y++) bm[y*64 + y] = 1'b1;
    out_ready = 1'b1;
    start_scan(bm);
    collect(6000);
    checks++;
    if (got_x.size() !== 24) begin
      failures++;
      $display("FAIL diag_count got=%0d exp=24", got_x.size());
    end else begin
      for (int k = 0; k < 24; k++) begin
        checks++;
        if (got_x[k] !== k || got_y[k] !== k) begin
          failures++;
          $display("FAIL diag_pixel idx=%0d got=(%0d,%0d) exp=(%0d,%0d)", k, got_x[k], got_y[k], k, k);
        end
      end
    end
    checks++;
    if (pix_count !== 13'd24) begin
      failures++;
      $display("FAIL diag_pix_count got=%0d exp=24", pix_count);
    end
    checks++;
    if (done_cycle !== 4120) begin
      failures++;
      $display("FAIL diag_latency got=%0d exp=4120", done_cycle);
    end
  endtask

  task automatic test_backpressure();
    logic [4095:0] bm;
    int wait_cyc;
    bm = {4096{1'b0}};
    bm[2*64 + 5] = 1'b1;
    bm[7*64 + 10] = 1'b1;
    out_ready = 1'b0;
    start_scan(bm);
    wait_cyc = 0;
    while (!out_valid && wait_cyc < 500) begin
      tick();
      wait_cyc++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_first_valid got=%0b exp=1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_x !== 6'd5 || out_y !== 6'd2 || pix_count !== 13'd0) begin
        failures++;
        $display("FAIL bp_stall cycle=%0d got=v%0b (%0d,%0d) n%0d exp=v1 (5,2) n0",
                 i, out_valid, out_x, out_y, pix_count);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || pix_count !== 13'd1) begin
      failures++;
      $display("FAIL bp_release got=v%0b n%0d exp=v0 n1", out_valid, pix_count);
    end
    collect(6000);
    checks++;
    if (got_x.size() !== 1) begin
      failures++;
      $display("FAIL bp_rest_count got=%0d exp=1", got_x.size());
    end else begin
      checks++;
      if (got_x[0] !== 10 || got_y[0] !== 7) begin
        failures++;
        $display("FAIL bp_second_pixel got=(%0d,%0d) exp=(10,7)", got_x[0], got_y[0]);
      end
    end
    checks++;
    if (pix_count !== 13'd2) begin
      failures++;
      $display("FAIL bp_pix_count got=%0d exp=2", pix_count);
    end
  endtask

  task automatic test_ignored_restart();
    logic [4095:0] bm;
    logic [4095:0] other;
    bm = {4096{1'b0}};
    bm[100] = 1'b1;
    bm[2000] = 1'b1;
    bm[4000] = 1'b1;
    other = {4096{1'b0}};
    other[7] = 1'b1;
    other[1000] = 1'b1;
    out_ready = 1'b1;
    start_scan(bm);
    for (int i = 0; i < 20; i++) tick();
    line_buffer = other;
    bla_done = 1'b1;
    tick();
    bla_done = 1'b0;
    collect(6000);
    checks++;
    if (got_x.size() !== 3) begin
      failures++;
      $display("FAIL restart_count got=%0d exp=3", got_x.size());
    end else begin
      checks++;
      if (got_x[0] !== 36 || got_y[0] !== 1 || got_x[1] !== 16 || got_y[1] !== 31 ||
          got_x[2] !== 32 || got_y[2] !== 62) begin
        failures++;
        $display("FAIL restart_pixels got=(%0d,%0d),(%0d,%0d),(%0d,%0d) exp=(36,1),(16,31),(32,62)",
                 got_x[0], got_y[0], got_x[1], got_y[1], got_x[2], got_y[2]);
      end
    end
    checks++;
    if (pix_count !== 13'd3) begin
      failures++;
      $display("FAIL restart_pix_count got=%0d exp=3", pix_count);
    end
  endtask

  task automatic test_midscan_reset_empty();
    logic [4095:0] bm;
    int wait_cyc;
    bm = {4096{1'b0}};
    bm[10] = 1'b1;
    out_ready = 1'b0;
    start_scan(bm);
    wait_cyc = 0;
    while (!out_valid && wait_cyc < 100) begin
      tick();
      wait_cyc++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_x !== 6'd10) begin
      failures++;
      $display("FAIL mid_emit_reached got=v%0b x%0d exp=v1 x10", out_valid, out_x);
    end
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_x, out_y, busy, scan_done, pix_count} !== 28'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%0b/%0d/%0d/%0b/%0b/%0d exp=all zero",
               out_valid, out_x, out_y, busy, scan_done, pix_count);
    end
    tick();
    n_rst = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_post_reset_busy got=%0b exp=0", busy);
    end
    start_scan({4096{1'b0}});
    collect(6000);
    checks++;
    if (done_cycle !== 4096) begin
      failures++;
      $display("FAIL empty_latency got=%0d exp=4096", done_cycle);
    end
    checks++;
    if (valid_seen !== 0 || got_x.size() !== 0) begin
      failures++;
      $display("FAIL empty_no_valid got=%0d exp=0", valid_seen);
    end
    checks++;
    if (pix_count !== 13'd0) begin
      failures++;
      $display("FAIL empty_pix_count got=%0d exp=0", pix_count);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      failures++;
      $display("FAIL empty_busy_after got=%0b exp=0", busy_after);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    bla_done = 1'b0;
    out_ready = 1'b0;
    line_buffer = {4096{1'b0}};
    test_reset();
    test_corners();
    test_diagonal();
    test_backpressure();
    test_ignored_restart();
    test_midscan_reset_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
